// File: rtl/glitch_sequencer.sv
// Register-bus slave that schedules delayed bursts of single-cycle glitch triggers after a capture trigger edge.
// Optional feature: define GLITCH_SEQ_AUTOREARM_EN to make CTRL bit2 a stored AUTOREARM bit (DONE -> ARMED).
module glitch_sequencer #(
    parameter logic [5:0] REG_ADDR = 6'd56,
    parameter int         DELAY_W  = 24
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [5:0]  reg_address,
    input  logic [15:0] reg_bytecnt,
    input  logic [7:0]  reg_datai,
    output logic [7:0]  reg_datao,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic        reg_addrvalid,
    input  logic [5:0]  reg_hypaddress,
    output logic [15:0] reg_hyplen,
    input  logic        trigger_i,
    output logic        glitch_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 trig_q;
    logic [7:0]           cfg_count_q, cfg_count_d;
    logic [DELAY_W-1:0]   cfg_delay_q, cfg_delay_d;
    logic [15:0]          cfg_spacing_q, cfg_spacing_d;
    logic [7:0]           wrk_count_q, wrk_count_d;
    logic [DELAY_W-1:0]   wrk_delay_q, wrk_delay_d;
    logic [15:0]          wrk_spacing_q, wrk_spacing_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic [7:0]           rem_q, rem_d;
    logic                 done_flag_q, done_flag_d;
    logic                 overrun_q, overrun_d;
    logic                 count_err_q, count_err_d;
    logic                 autorearm_q, autorearm_d;

    logic                 addr_hit;
    logic                 wr_en;
    logic [2:0]           byte_sel;
    logic                 ctrl_wr;
    logic                 arm;
    logic                 abort;
    logic                 trig_edge;
    logic                 busy;
    logic [7:0]           ctrl_rd;
    logic [7:0]           status_rd;
    logic                 unused_read;

    assign unused_read = reg_read;

    assign addr_hit  = (reg_address == REG_ADDR) && (reg_bytecnt < 16'd8);
    assign wr_en     = reg_write && reg_addrvalid && addr_hit;
    assign byte_sel  = reg_bytecnt[2:0];
    assign ctrl_wr   = wr_en && (byte_sel == 3'd0);
    assign arm       = ctrl_wr && reg_datai[0];
    assign abort     = ctrl_wr && reg_datai[1];
    assign trig_edge = trigger_i && !trig_q;
    assign busy      = (state_q != S_IDLE);

    assign glitch_o   = (state_q == S_PULSE);
    assign done_o     = (state_q == S_DONE);
    assign busy_o     = busy;
    assign reg_hyplen = (reg_hypaddress == REG_ADDR) ? 16'd8 : 16'd0;

`ifdef GLITCH_SEQ_AUTOREARM_EN
    assign ctrl_rd = {5'd0, autorearm_q, 2'd0};
`else
    assign ctrl_rd = 8'd0;
`endif

    assign status_rd = {1'b0, state_q, count_err_q, overrun_q, done_flag_q, busy};

    always_comb begin
        reg_datao = 8'd0;
        if (addr_hit) begin
            case (byte_sel)
                3'd0:    reg_datao = ctrl_rd;
                3'd1:    reg_datao = cfg_count_q;
                3'd2:    reg_datao = cfg_delay_q[7:0];
                3'd3:    reg_datao = cfg_delay_q[15:8];
                3'd4:    reg_datao = cfg_delay_q[23:16];
                3'd5:    reg_datao = cfg_spacing_q[7:0];
                3'd6:    reg_datao = cfg_spacing_q[15:8];
                default: reg_datao = status_rd;
            endcase
        end
    end

    // Configuration bytes are frozen while a burst is in flight.
    always_comb begin
        cfg_count_d   = cfg_count_q;
        cfg_delay_d   = cfg_delay_q;
        cfg_spacing_d = cfg_spacing_q;
        autorearm_d   = autorearm_q;
`ifdef GLITCH_SEQ_AUTOREARM_EN
        if (ctrl_wr) begin
            autorearm_d = reg_datai[2];
        end
`endif
        if (wr_en && !busy) begin
            case (byte_sel)
                3'd1:    cfg_count_d          = reg_datai;
                3'd2:    cfg_delay_d[7:0]     = reg_datai;
                3'd3:    cfg_delay_d[15:8]    = reg_datai;
                3'd4:    cfg_delay_d[23:16]   = reg_datai;
                3'd5:    cfg_spacing_d[7:0]   = reg_datai;
                3'd6:    cfg_spacing_d[15:8]  = reg_datai;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        wrk_count_d   = wrk_count_q;
        wrk_delay_d   = wrk_delay_q;
        wrk_spacing_d = wrk_spacing_q;
        done_flag_d   = done_flag_q;
        overrun_d     = overrun_q;
        count_err_d   = count_err_q;

        if (trig_edge && (state_q == S_DELAY || state_q == S_PULSE || state_q == S_GAP)) begin
            overrun_d = 1'b1;
        end

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        if (cfg_count_q != 8'd0) begin
                            state_d       = S_ARMED;
                            wrk_count_d   = cfg_count_q;
                            wrk_delay_d   = cfg_delay_q;
                            wrk_spacing_d = cfg_spacing_q;
                            done_flag_d   = 1'b0;
                            overrun_d     = 1'b0;
                            count_err_d   = 1'b0;
                        end else begin
                            count_err_d = 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (trig_edge) begin
                        state_d = S_DELAY;
                        cnt_d   = wrk_delay_q;
                        rem_d   = wrk_count_q;
                    end
                end
                S_DELAY, S_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = S_PULSE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_PULSE: begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = {8'd0, wrk_spacing_q};
                    end
                end
                S_DONE: begin
                    done_flag_d = 1'b1;
                    state_d     = S_IDLE;
`ifdef GLITCH_SEQ_AUTOREARM_EN
                    if (autorearm_q) begin
                        state_d       = S_ARMED;
                        wrk_count_d   = cfg_count_q;
                        wrk_delay_d   = cfg_delay_q;
                        wrk_spacing_d = cfg_spacing_q;
                    end
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            trig_q        <= 1'b0;
            cfg_count_q   <= '0;
            cfg_delay_q   <= '0;
            cfg_spacing_q <= '0;
            wrk_count_q   <= '0;
            wrk_delay_q   <= '0;
            wrk_spacing_q <= '0;
            cnt_q         <= '0;
            rem_q         <= '0;
            done_flag_q   <= 1'b0;
            overrun_q     <= 1'b0;
            count_err_q   <= 1'b0;
            autorearm_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            trig_q        <= trigger_i;
            cfg_count_q   <= cfg_count_d;
            cfg_delay_q   <= cfg_delay_d;
            cfg_spacing_q <= cfg_spacing_d;
            wrk_count_q   <= wrk_count_d;
            wrk_delay_q   <= wrk_delay_d;
            wrk_spacing_q <= wrk_spacing_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            done_flag_q   <= done_flag_d;
            overrun_q     <= overrun_d;
            count_err_q   <= count_err_d;
            autorearm_q   <= autorearm_d;
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: bursts are predicted from trigger time and programmed timing.
module tb_glitch_sequencer;

    localparam logic [5:0] ADDR = 6'd56;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [5:0]  reg_address = 6'd0;
    logic [15:0] reg_bytecnt = 16'd0;
    logic [7:0]  reg_datai = 8'd0;
    logic [7:0]  reg_datao;
    logic        reg_read = 1'b0;
    logic        reg_write = 1'b0;
    logic        reg_addrvalid = 1'b0;
    logic [5:0]  reg_hypaddress = 6'd0;
    logic [15:0] reg_hyplen;
    logic        trigger_i = 1'b0;
    logic        glitch_o;
    logic        busy_o;
    logic        done_o;

    glitch_sequencer dut (
        .clk(clk),
        .reset_i(reset_i),
        .reg_address(reg_address),
        .reg_bytecnt(reg_bytecnt),
        .reg_datai(reg_datai),
        .reg_datao(reg_datao),
        .reg_read(reg_read),
        .reg_write(reg_write),
        .reg_addrvalid(reg_addrvalid),
        .reg_hypaddress(reg_hypaddress),
        .reg_hyplen(reg_hyplen),
        .trigger_i(trigger_i),
        .glitch_o(glitch_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Every output pulse consumes the oldest prediction; kind and cycle must both match.
    always @(negedge clk) begin
        if (!reset_i && (glitch_o || done_o)) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_pulse: glitch=%0b done=%0b at cycle %0d, expected no pulse",
                         glitch_o, done_o, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("pulse_kind_done", {31'd0, done_o}, {31'd0, e.is_done});
                checkOutput("pulse_kind_glitch", {31'd0, glitch_o}, {31'd0, !e.is_done});
                checkOutput("pulse_cycle", cyc, e.at);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) nextCycle();
    endtask

    task automatic writeReg(input int idx, input logic [7:0] d);
        reg_address   = ADDR;
        reg_bytecnt   = 16'(idx);
        reg_datai     = d;
        reg_write     = 1'b1;
        reg_addrvalid = 1'b1;
        nextCycle();
        reg_write     = 1'b0;
        reg_addrvalid = 1'b0;
        reg_address   = 6'd0;
    endtask

    task automatic readReg(input int idx, output logic [7:0] d);
        reg_address   = ADDR;
        reg_bytecnt   = 16'(idx);
        reg_read      = 1'b1;
        reg_addrvalid = 1'b1;
        #1;
        d = reg_datao;
        reg_read      = 1'b0;
        reg_addrvalid = 1'b0;
        reg_address   = 6'd0;
    endtask

    task automatic pulseTrigger(output int n);
        trigger_i = 1'b1;
        n = cyc;
        nextCycle();
        trigger_i = 1'b0;
    endtask

    // Reference timing: first pulse DELAY+2 after the edge, then every SPACING+2, done one after the last.
    task automatic pushBurst(input int n, input int count, input int delay, input int spacing);
        exp_t e;
        int last;
        last = n;
        for (int k = 0; k < count; k++) begin
            e.is_done = 1'b0;
            e.at = n + delay + 2 + k * (spacing + 2);
            last = e.at;
            sbq.push_back(e);
        end
        e.is_done = 1'b1;
        e.at = last + 1;
        sbq.push_back(e);
    endtask

    task automatic writeConfig(input int count, input int delay, input int spacing);
        logic [23:0] dl;
        logic [15:0] sp;
        dl = 24'(delay);
        sp = 16'(spacing);
        writeReg(1, 8'(count));
        writeReg(2, dl[7:0]);
        writeReg(3, dl[15:8]);
        writeReg(4, dl[23:16]);
        writeReg(5, sp[7:0]);
        writeReg(6, sp[15:8]);
    endtask

    task automatic waitDrain(input int budget);
        int b;
        b = budget;
        while (sbq.size() != 0 && b > 0) begin
            nextCycle();
            b--;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: %0d predicted pulses still pending at cycle %0d, expected 0",
                     sbq.size(), cyc);
            sbq.delete();
        end
    endtask

    task automatic applyStimulus(input int count, input int delay, input int spacing, input int pre_wait);
        int n;
        writeConfig(count, delay, spacing);
        writeReg(0, 8'h01);
        repeat (pre_wait) nextCycle();
        pulseTrigger(n);
        pushBurst(n, count, delay, spacing);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        int n;
        int cnt;
        int dly;
        int spc;

        repeat (3) nextCycle();
        reset_i = 1'b0;
        nextCycle();

        checkOutput("reset_glitch", {31'd0, glitch_o}, 0);
        checkOutput("reset_busy", {31'd0, busy_o}, 0);
        checkOutput("reset_done", {31'd0, done_o}, 0);
        checkOutput("reset_datao_unaddressed", {24'd0, reg_datao}, 0);
        readReg(7, rd);
        checkOutput("reset_status", {24'd0, rd}, 0);
        reg_hypaddress = ADDR;
        #1;
        checkOutput("hyplen_match", {16'd0, reg_hyplen}, 8);
        reg_hypaddress = 6'd57;
        #1;
        checkOutput("hyplen_other", {16'd0, reg_hyplen}, 0);

        $display("[TB] single pulse, zero delay");
        applyStimulus(1, 0, 0, 0);
        waitDrain(200);
        readReg(7, rd);
        checkOutput("single_status", {24'd0, rd}, 8'h02);

        $display("[TB] three pulses, delay 10, spacing 4");
        applyStimulus(3, 10, 4, 2);
        waitDrain(200);
        readReg(7, rd);
        checkOutput("burst3_status", {24'd0, rd}, 8'h02);

        $display("[TB] count zero arm");
        writeReg(1, 8'h00);
        writeReg(0, 8'h01);
        readReg(7, rd);
        checkOutput("cnt0_count_err", {31'd0, rd[3]}, 1);
        checkOutput("cnt0_state", {29'd0, rd[6:4]}, 0);
        checkOutput("cnt0_busy", {31'd0, busy_o}, 0);
        pulseTrigger(n);
        repeat (40) nextCycle();

        $display("[TB] abort after second pulse with overrun");
        writeConfig(5, 5, 100);
        writeReg(0, 8'h01);
        pulseTrigger(n);
        pushBurst(n, 2, 5, 100);
        sbq.pop_back();
        waitUntil(n + 50);
        pulseTrigger(cnt);
        waitUntil(n + 115);
        writeReg(0, 8'h02);
        checkOutput("abort_busy", {31'd0, busy_o}, 0);
        readReg(7, rd);
        checkOutput("abort_status", {24'd0, rd}, 8'h04);
        repeat (250) nextCycle();
        checkOutput("abort_pending", sbq.size(), 0);

        $display("[TB] randomized bursts");
        for (int i = 0; i < 10; i++) begin
            cnt = int'($urandom_range(4, 1));
            dly = int'($urandom_range(40, 0));
            spc = int'($urandom_range(20, 0));
            applyStimulus(cnt, dly, spc, int'($urandom_range(3, 0)));
            waitDrain(2000);
            readReg(7, rd);
            checkOutput("rand_status", {24'd0, rd}, 8'h02);
            readReg(1, rd);
            checkOutput("rand_count_rb", {24'd0, rd}, cnt);
            readReg(5, rd);
            checkOutput("rand_spacing_rb", {24'd0, rd}, spc);
        end

        $display("[TB] reset during delay");
        writeConfig(2, 60, 5);
        writeReg(0, 8'h01);
        pulseTrigger(n);
        repeat (10) nextCycle();
        reset_i = 1'b1;
        nextCycle();
        checkOutput("midreset_glitch", {31'd0, glitch_o}, 0);
        checkOutput("midreset_busy", {31'd0, busy_o}, 0);
        checkOutput("midreset_done", {31'd0, done_o}, 0);
        reset_i = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            readReg(b, rd);
            checkOutput("midreset_cfg_rb", {24'd0, rd}, 0);
        end
        readReg(7, rd);
        checkOutput("midreset_status", {24'd0, rd}, 0);
        repeat (100) nextCycle();

`ifdef GLITCH_SEQ_AUTOREARM_EN
        $display("[TB] autorearm bursts");
        writeConfig(2, 3, 4);
        writeReg(0, 8'h05);
        readReg(0, rd);
        checkOutput("autorearm_ctrl_rb", {24'd0, rd}, 8'h04);
        for (int t = 0; t < 3; t++) begin
            pulseTrigger(n);
            pushBurst(n, 2, 3, 4);
            waitDrain(200);
            waitUntil(n + 1000);
            checkOutput("autorearm_busy", {31'd0, busy_o}, 1);
        end
        writeReg(0, 8'h02);
        checkOutput("autorearm_abort_busy", {31'd0, busy_o}, 0);
`endif

        checkOutput("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/glitch_sequencer.md
# glitch_sequencer

Register-bus slave that schedules bursts of clock-glitch triggers relative to a capture trigger. Sits beside the clock-glitch register block on the shared 8-bit register bus. Its `glitch_o` drives the glitch block's external-trigger input in place of the raw trigger. After a programmed delay from a trigger edge, it emits a programmed number of single-cycle pulses at a programmed spacing, then reports done.

## Interface

Parameters:
- `REG_ADDR`, 6'd56: register address owned by this block.
- `DELAY_W`, 24: delay counter width; fixed at 24.

Ports:
- `clk`  in  1  register/system clock; the block's only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `reg_address`  in  6  bus address.
- `reg_bytecnt`  in  16  byte index within the register.
- `reg_datai`  in  8  write data from the bus master.
- `reg_datao`  out  8  read data; 0 when not addressed (the bus ORs all slaves).
- `reg_read`  in  1  read strobe.
- `reg_write`  in  1  write strobe.
- `reg_addrvalid`  in  1  address-valid qualifier.
- `reg_hypaddress`  in  6  length-query address.
- `reg_hyplen`  out  16  8 when `reg_hypaddress == REG_ADDR`, else 0.
- `trigger_i`  in  1  capture trigger, already synchronous to `clk`.
- `glitch_o`  out  1  glitch trigger pulse to the clock-glitch block.
- `busy_o`  out  1  high when state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse when a burst completes.

## Operation

Register `REG_ADDR` is 8 bytes, little-endian multi-byte fields:
- B0 CTRL (write): bit0 ARM, bit1 ABORT, self-clearing. Reads return 0 except bit2 when `GLITCH_SEQ_AUTOREARM_EN` is defined.
- B1 COUNT: number of pulses, 1..255.
- B2–B4 DELAY: 24-bit delay.
- B5–B6 SPACING: 16-bit spacing.
- B7 STATUS (read-only): bit0 busy, bit1 done (sticky), bit2 overrun (sticky), bit3 count_err (sticky), bits6:4 state code, bit7 0.

Bus rules:
- Write: `reg_write & reg_addrvalid & reg_address==REG_ADDR & reg_bytecnt<8` writes the selected byte.
- Writes to B1–B6 while busy are ignored. COUNT, DELAY and SPACING are copied to working registers at ARM.
- Read mux is combinational on address and bytecnt. `reg_datao` = 0 when unaddressed or `bytecnt>=8`.

States: IDLE(0), ARMED(1), DELAY(2), PULSE(3), GAP(4), DONE(5).
- Trigger edge = `trigger_i & ~trig_q`, where `trig_q` is `trigger_i` registered.
- IDLE: ARM with COUNT≠0 → ARMED, and clears done/overrun/count_err. ARM with COUNT=0 → stays IDLE and sets count_err.
- ARMED: on edge → DELAY, cnt←DELAY, rem←COUNT.
- DELAY: cnt==0 → PULSE, else cnt−1.
- PULSE: `glitch_o`=1, rem−1. If rem was 1 → DONE, else → GAP with cnt←SPACING.
- GAP: cnt==0 → PULSE, else cnt−1.
- DONE: `done_o`=1 for one cycle, done flag set → IDLE (or ARMED, see Configuration).
- ABORT in any state → IDLE next cycle. Abort does not set done. ABORT takes priority over ARM in the same write.
- A trigger edge seen in DELAY, PULSE or GAP sets overrun. The burst continues.
- ARM while not IDLE is ignored.

## Timing

- Reset values: state IDLE; all config, working and status registers 0; `glitch_o`=0, `busy_o`=0, `done_o`=0, `reg_datao`=0, `reg_hyplen`=0 (or 8 when `reg_hypaddress` matches).
- Edge sampled at cycle N puts the first `glitch_o` high at cycle N+DELAY+2.
- Successive pulses are SPACING+2 cycles apart.
- `done_o` is high the cycle after the last pulse.
- `glitch_o` and `done_o` are decoded from the registered state: glitch-free and exactly one cycle wide.
- ARM written at cycle W: ARMED at W+1; the earliest accepted edge is sampled at W+1.
- Reset asserted mid-burst: IDLE and all outputs 0 on the next edge; no further pulses.

## Configuration

- `GLITCH_SEQ_AUTOREARM_EN` defined: CTRL bit2 AUTOREARM is a stored, readable bit. When set, DONE → ARMED with working registers reloaded from config, so every trigger edge produces a burst until ABORT.
- Not defined: bit2 is ignored and reads 0; DONE → IDLE always.

## Test plan

- COUNT=1, DELAY=0, ARM, edge at N → single `glitch_o` at N+2, `done_o` at N+3, STATUS=0x02.
- COUNT=3, DELAY=10, SPACING=4, edge at N → pulses at N+12, N+18, N+24; `done_o` at N+25.
- COUNT=0, ARM → remains IDLE, STATUS bit3=1, `busy_o`=0, no pulses on edges.
- COUNT=5, SPACING=100, ABORT after the 2nd pulse → no further pulses, `busy_o`=0 next cycle, done=0. A second edge during GAP beforehand sets overrun.
- Reset asserted during DELAY → all outputs 0 the next cycle; readback of B1–B6 = 0; `reg_hyplen`=8 only for `REG_ADDR`.
- With `GLITCH_SEQ_AUTOREARM_EN`, AUTOREARM=1, COUNT=2, three edges spaced 1000 cycles → six pulses, three `done_o` pulses, `busy_o` stays 1.
